// File: rtl/mult_norm_pkg.sv
// Shared types and defaults for the multiplier post-product normalization sequencer.
package mult_norm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT1 = 3'd1,
    S_ROUND  = 3'd2,
    S_CHECK  = 3'd3,
    S_SHIFT2 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int ROUND_LAT_DEF = 2;
  localparam int CNT_W_DEF     = 4;

endpackage

// File: rtl/mult_norm_ctrl_lat_down_counter.sv
// Loadable down counter that saturates at zero; times the rounding-stage wait.
module lat_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/mult_norm_ctrl.sv
// Post-product normalization sequencer: first shift, rounding wait,
// optional renormalization shift, then a completion pulse.
module mult_norm_ctrl
  import mult_norm_pkg::*;
#(
  parameter int ROUND_LAT = ROUND_LAT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic flush_i,
  input  logic prod_ovf_i,
  input  logic round_ovf_i,
  output logic shift_value_o,
  output logic load_o,
  output logic exp_inc_o,
  output logic round_en_o,
  output logic busy_o,
  output logic ready_o,
  output logic renorm_o
);

  localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(ROUND_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_sel;
  logic             r_renorm;
  logic             r_first;
  logic             w_accept;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_en;
  logic             w_cnt_zero;

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;

  lat_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (w_cnt_load),
    .load_val(w_cnt_val),
    .en      (w_cnt_en),
    .zero_o  (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_renorm <= 1'b0;
      r_first  <= 1'b0;
    end else begin
      r_state <= w_next;
      // marks the first ROUND cycle for the round_en pulse
      r_first <= (r_state == S_SHIFT1) && !flush_i;
      if (w_accept) begin
        r_sel    <= prod_ovf_i;
        r_renorm <= 1'b0;
      end else if ((r_state == S_SHIFT2) && !flush_i) begin
        r_renorm <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    shift_value_o = 1'b0;
    load_o        = 1'b0;
    exp_inc_o     = 1'b0;
    round_en_o    = 1'b0;
    busy_o        = 1'b0;
    ready_o       = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_val     = LP_WAIT;
    w_cnt_en      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_SHIFT1;
      end
      S_SHIFT1: begin
        busy_o        = 1'b1;
        load_o        = 1'b1;
        shift_value_o = r_sel;
        exp_inc_o     = r_sel;
        w_cnt_load    = 1'b1;
        w_next        = S_ROUND;
      end
      S_ROUND: begin
        busy_o     = 1'b1;
        round_en_o = r_first;
        w_cnt_en   = 1'b1;
        if (w_cnt_zero) w_next = S_CHECK;
      end
      S_CHECK: begin
        busy_o = 1'b1;
        w_next = round_ovf_i ? S_SHIFT2 : S_DONE;
      end
      S_SHIFT2: begin
        busy_o        = 1'b1;
        load_o        = 1'b1;
        shift_value_o = 1'b1;
        exp_inc_o     = 1'b1;
        w_next        = S_DONE;
      end
      S_DONE: begin
        busy_o  = 1'b1;
        ready_o = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_next     = S_IDLE;
      w_cnt_load = 1'b1;
      w_cnt_val  = '0;
    end
  end

  assign renorm_o = r_renorm;

endmodule

// File: tb/tb_mult_norm_ctrl.sv
// Bench for mult_norm_ctrl at ROUND_LAT = 2, 1 and 15 against a
// cycle-timeline model of one normalization operation.
module tb_mult_norm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic prod = 1'b0;
  logic rov = 1'b0;

  always #5 clk = ~clk;

  // {shift, load, exp_inc, round_en, busy, ready, renorm}
  logic [6:0] w_o [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic sh, ld, ex, re, bz, rd, rn;
    mult_norm_ctrl #(
      .ROUND_LAT(g == 0 ? 2 : (g == 1 ? 1 : 15)),
      .CNT_W    (4)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .flush_i      (flush),
      .prod_ovf_i   (prod),
      .round_ovf_i  (rov),
      .shift_value_o(sh),
      .load_o       (ld),
      .exp_inc_o    (ex),
      .round_en_o   (re),
      .busy_o       (bz),
      .ready_o      (rd),
      .renorm_o     (rn)
    );
    assign w_o[g] = {sh, ld, ex, re, bz, rd, rn};
  end

  int L [3] = '{2, 1, 15};

  // model: t = cycles since accepted start (0 = idle), endc = DONE cycle
  int t    [3] = '{0, 0, 0};
  int endc [3] = '{0, 0, 0};
  bit sel  [3] = '{0, 0, 0};
  bit ren  [3] = '{0, 0, 0};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int st      = 0;
  int rdy_n   [3];
  int rdy_cyc [3];
  int exp_n   [3];
  int ld_n    [3];

  function automatic logic [6:0] exp_o(int k);
    bit s2, ld, sh, re, bz, rd;
    s2 = (endc[k] == 4 + L[k]);
    ld = (t[k] == 1) || (s2 && t[k] == 3 + L[k]);
    sh = (t[k] == 1 && sel[k]) || (s2 && t[k] == 3 + L[k]);
    re = (t[k] == 2);
    bz = (t[k] != 0);
    rd = (t[k] != 0) && (t[k] == endc[k]);
    return {sh, ld, sh, re, bz, rd, ren[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      t[k] = 0; endc[k] = 0; sel[k] = 0; ren[k] = 0;
    end
  endtask

  task automatic model_upd();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (flush) begin
          t[k] = 0; endc[k] = 0;
        end else if (t[k] == 0) begin
          if (start) begin
            t[k] = 1; sel[k] = prod; ren[k] = 0; endc[k] = 0;
          end
        end else begin
          if (t[k] == 2 + L[k]) endc[k] = rov ? 4 + L[k] : 3 + L[k];
          if (endc[k] == 4 + L[k] && t[k] == 3 + L[k]) ren[k] = 1;
          if (t[k] == endc[k]) begin
            t[k] = 0; endc[k] = 0;
          end else begin
            t[k]++;
          end
        end
      end
    end
  endtask

  task automatic chk(string nm, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic clr_obs();
    for (int k = 0; k < 3; k++) begin
      rdy_n[k] = 0; rdy_cyc[k] = -1; exp_n[k] = 0; ld_n[k] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_upd();
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (w_o[k] !== exp_o(k)) begin
        n_fail++;
        $display("FAIL out dut%0d cyc %0d: got %b expected %b",
                 k, cyc, w_o[k], exp_o(k));
      end
      if (w_o[k][1]) begin rdy_n[k]++; rdy_cyc[k] = cyc - st; end
      if (w_o[k][4]) exp_n[k]++;
      if (w_o[k][5]) ld_n[k]++;
    end
  endtask

  function automatic bit all_idle();
    return (t[0] == 0) && (t[1] == 0) && (t[2] == 0);
  endfunction

  task automatic drain(input bit hold);
    bit done;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      if (hold) start = (t[0] != 0);
      if (all_idle() && !start) begin done = 1; break; end
      step();
    end
    start = 0;
    chk("drain_timeout", int'(done), 1);
  endtask

  task automatic launch(input bit p, input bit r);
    start = 1; prod = p; rov = r;
    st = cyc;
    clr_obs();
    step();
    start = 0;
  endtask

  task automatic pulse_rst();
    rst = 1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("async_rst dut%0d", k), int'(w_o[k]), 0);
    model_reset();
  endtask

  int lat_plain [3] = '{5, 4, 18};
  int lat_ren   [3] = '{6, 5, 19};

  initial begin
    step();
    step();
    rst = 0;
    step();

    launch(0, 0);
    drain(0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("p0r0 ready_cyc dut%0d", k), rdy_cyc[k], lat_plain[k]);
      chk($sformatf("p0r0 exp_n dut%0d", k), exp_n[k], 0);
      chk($sformatf("p0r0 renorm dut%0d", k), int'(w_o[k][0]), 0);
    end

    launch(1, 0);
    drain(0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("p1r0 ready_cyc dut%0d", k), rdy_cyc[k], lat_plain[k]);
      chk($sformatf("p1r0 exp_n dut%0d", k), exp_n[k], 1);
      chk($sformatf("p1r0 ld_n dut%0d", k), ld_n[k], 1);
    end

    launch(1, 1);
    drain(0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("p1r1 ready_cyc dut%0d", k), rdy_cyc[k], lat_ren[k]);
      chk($sformatf("p1r1 exp_n dut%0d", k), exp_n[k], 2);
      chk($sformatf("p1r1 ld_n dut%0d", k), ld_n[k], 2);
      chk($sformatf("p1r1 renorm dut%0d", k), int'(w_o[k][0]), 1);
    end
    step();
    chk("renorm sticky", int'(w_o[0][0]), 1);

    launch(0, 0);
    drain(1);
    chk("restart ignored rdy_n", rdy_n[0], 1);
    chk("restart ignored cyc", rdy_cyc[0], 5);

    launch(1, 1);
    step(); step(); step();
    flush = 1;
    step();
    flush = 0;
    drain(0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("flush rdy_n dut%0d", k), rdy_n[k], 0);
    chk("flush in CHECK ld_n", ld_n[0], 1);
    chk("flush renorm holds", int'(w_o[0][0]), 0);

    launch(1, 0);
    step();
    pulse_rst();
    step();
    rst = 0;
    step();
    launch(0, 0);
    drain(0);
    chk("post-rst ready_cyc", rdy_cyc[0], 5);

    for (int i = 0; i < 1200; i++) begin
      start = ($urandom % 3) == 0;
      flush = ($urandom % 25) == 0;
      prod  = 1'($urandom);
      rov   = 1'($urandom);
      if (($urandom % 200) == 0) begin
        pulse_rst();
        step();
        rst = 0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
